// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe: pipelined Sklansky prefix adder/subtractor with valid/ready back-pressure
// Ports: clk, rst_n (async, active low); in_valid/in_ready, x, y, cin, op_sub, sat input beat;
//        out_valid/out_ready, sum, cout, ovf result beat.
// Option: PREFIX_ADDER_SAT_EN adds the sat input and signed saturation of sum.
module prefix_adder_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             op_sub,
`ifdef PREFIX_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int LEVELS = $clog2(WIDTH);
  if (WIDTH < 2 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("prefix_adder_pipe: WIDTH must be a power of two in 2..64");
  end
  // bank 0 holds the registered pre-stage, bank l+1 the result of prefix level l
  logic [LEVELS:0]            v_q, v_d, c0_q, c0_d;
  logic [LEVELS:0][WIDTH-1:0] p_q, p_d, g_q, g_d, a_q, a_d;
  logic [WIDTH-1:0]           y_m, c;
  logic                       adv, unused_a;
`ifdef PREFIX_ADDER_SAT_EN
  logic [LEVELS:0]            s_q, s_d, xs_q, xs_d;
`endif
  always_comb begin
    y_m = op_sub ? ~y : y;
    v_d = {v_q[LEVELS-1:0], in_valid};
    c0_d = {c0_q[LEVELS-1:0], op_sub | cin};
    p_d = {p_q[LEVELS-1:0], x ^ y_m};
    g_d = {g_q[LEVELS-1:0], x & y_m};
    a_d = {a_q[LEVELS-1:0], x | y_m};
    // carry-in folded into bit 0, so each final group G is the carry into the next bit
    g_d[0][0] = g_d[0][0] | (a_d[0][0] & c0_d[0]);
    // upper half of each 2^(l+1) block absorbs the top bit of its lower half
    for (int l = 0; l < LEVELS; l++)
      for (int i = 0; i < WIDTH; i++)
        if (i[l]) begin
          g_d[l+1][i] = g_q[l][i] | (a_q[l][i] & g_q[l][(i | ((1 << l) - 1)) ^ (1 << l)]);
          a_d[l+1][i] = a_q[l][i] & a_q[l][(i | ((1 << l) - 1)) ^ (1 << l)];
        end
`ifdef PREFIX_ADDER_SAT_EN
    s_d = {s_q[LEVELS-1:0], sat};
    xs_d = {xs_q[LEVELS-1:0], x[WIDTH-1]};
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q <= '0;
      c0_q <= '0;
      p_q <= '0;
      g_q <= '0;
      a_q <= '0;
`ifdef PREFIX_ADDER_SAT_EN
      s_q <= '0;
      xs_q <= '0;
`endif
    end else if (adv) begin
      v_q <= v_d;
      c0_q <= c0_d;
      p_q <= p_d;
      g_q <= g_d;
      a_q <= a_d;
`ifdef PREFIX_ADDER_SAT_EN
      s_q <= s_d;
      xs_q <= xs_d;
`endif
    end
  assign adv = ~v_q[LEVELS] | out_ready;
  assign in_ready = adv;
  assign out_valid = v_q[LEVELS];
  assign c = {g_q[LEVELS][WIDTH-2:0], c0_q[LEVELS]};
  assign cout = g_q[LEVELS][WIDTH-1];
  assign ovf = c[WIDTH-1] ^ cout;
  assign unused_a = ^a_q[LEVELS];
`ifdef PREFIX_ADDER_SAT_EN
  // on overflow both operands share x's sign, which is the sign of the true result
  assign sum = (s_q[LEVELS] & ovf) ? {xs_q[LEVELS], {(WIDTH-1){~xs_q[LEVELS]}}} : c ^ p_q[LEVELS];
`else
  assign sum = c ^ p_q[LEVELS];
`endif
endmodule
